// File: rtl/vec_red_acc_i8.sv
`timescale 1ns/1ps
// vec_red_acc_i8: reduces signed product vectors through a registered adder
// tree and accumulates num_blocks reduced vectors into one dot-product result,
// delivered on a valid/ready output with full backpressure.
module vec_red_acc_i8 #(
   parameter int unsigned prd_width  = 16,
   parameter int unsigned length     = 32,
   parameter int unsigned num_blocks = 4,
   parameter int unsigned acc_width  = 23
) (
   input  logic                                  i_clk,
   input  logic                                  i_rst_n,
   input  logic [length-1:0][prd_width-1:0]      i_prd,
   input  logic                                  i_valid,
   output logic                                  o_ready,
   output logic signed [acc_width-1:0]           o_sum,
   output logic                                  o_valid,
   input  logic                                  i_ready
);

   localparam int unsigned tree_depth = $clog2(length);
   localparam int unsigned cnt_width  = (num_blocks > 1) ? $clog2(num_blocks) : 1;
   localparam logic [cnt_width-1:0] cnt_last = cnt_width'(num_blocks - 1);

   // Whole pipeline advances together; it only stalls when a result is stuck
   logic en;
   assign en      = !o_valid || i_ready;
   assign o_ready = en;

   // Level 0 holds the input vector; level k holds length>>k sums of prd_width+k bits
   for (genvar k = 0; k <= tree_depth; k++) begin : g_lvl
      localparam int unsigned n = length >> k;
      localparam int unsigned w = prd_width + k;

      logic [n-1:0][w-1:0] sum;
      logic                vld;

      if (k == 0) begin : g_in
         // Capture the incoming product vector
         always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
               sum <= '0;
               vld <= 1'b0;
            end else if (en) begin
               sum <= i_prd;
               vld <= i_valid;
            end
         end
      end else begin : g_add
         // Pairwise signed add of the previous level, sign-extended by one bit
         always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
               sum <= '0;
               vld <= 1'b0;
            end else if (en) begin
               for (int j = 0; j < int'(n); j++) begin
                  sum[j] <= w'($signed(g_lvl[k-1].sum[2*j])) +
                            w'($signed(g_lvl[k-1].sum[2*j+1]));
               end
               vld <= g_lvl[k-1].vld;
            end
         end
      end
   end

   // Tree result widened to accumulator width ahead of the accumulate stage
   logic signed [acc_width-1:0] ext_sum;
   logic                        ext_vld;

   // Register the sign-extended tree output
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         ext_sum <= '0;
         ext_vld <= 1'b0;
      end else if (en) begin
         ext_sum <= acc_width'($signed(g_lvl[tree_depth].sum[0]));
         ext_vld <= g_lvl[tree_depth].vld;
      end
   end

   logic signed [acc_width-1:0] acc;
   logic signed [acc_width-1:0] acc_next;
   logic [cnt_width-1:0]        cnt;

   // First block of a result restarts the sum, later blocks add onto it
   always_comb begin
      acc_next = acc + ext_sum;
      if (cnt == '0) begin
         acc_next = ext_sum;
      end
   end

   // Block accumulation and output handshake
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         acc     <= '0;
         cnt     <= '0;
         o_sum   <= '0;
         o_valid <= 1'b0;
      end else begin
         if (o_valid && i_ready) begin
            o_valid <= 1'b0;
         end
         if (en && ext_vld) begin
            acc <= acc_next;
            if (cnt == cnt_last) begin
               o_sum   <= acc_next;
               o_valid <= 1'b1;
               cnt     <= '0;
            end else begin
               cnt <= cnt + 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_vec_red_acc_i8.sv
`timescale 1ns/1ps
// tb_vec_red_acc_i8: directed vectors with hand-computed dot-product results.
module tb_vec_red_acc_i8;

   localparam int unsigned prd_width  = 16;
   localparam int unsigned length     = 32;
   localparam int unsigned num_blocks = 4;
   localparam int unsigned acc_width  = 23;
   localparam longint      none       = 64'sh7fff_ffff_ffff_ffff;

   logic                              i_clk   = 1'b0;
   logic                              i_rst_n = 1'b0;
   logic                              i_valid = 1'b0;
   logic                              i_ready = 1'b1;
   logic [length-1:0][prd_width-1:0]  i_prd   = '0;
   logic                              o_ready;
   logic                              o_valid;
   logic signed [acc_width-1:0]       o_sum;

   int     cyc     = 0;
   int     n_cmp   = 0;
   int     n_bad   = 0;
   int     stalls  = 0;
   int     acc_cyc = 0;
   longint res_q[$];
   int     cyc_q[$];

   vec_red_acc_i8 #(
      .prd_width (prd_width),
      .length    (length),
      .num_blocks(num_blocks),
      .acc_width (acc_width)
   ) dut (
      .i_clk  (i_clk),
      .i_rst_n(i_rst_n),
      .i_prd  (i_prd),
      .i_valid(i_valid),
      .o_ready(o_ready),
      .o_sum  (o_sum),
      .o_valid(o_valid),
      .i_ready(i_ready)
   );

   always #5 i_clk = ~i_clk;

   always @(posedge i_clk) cyc <= cyc + 1;

   // Record every result handed downstream, with the edge it became visible on
   always @(negedge i_clk) begin
      if (i_rst_n && o_valid && i_ready) begin
         res_q.push_back(longint'(o_sum));
         cyc_q.push_back(cyc);
      end
   end

   task automatic check(input string tag, input longint got, input longint exp);
      n_cmp++;
      if (got != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge i_clk);
      #1;
   endtask

   task automatic fill(input int v);
      for (int i = 0; i < int'(length); i++) i_prd[i] = 16'(v);
   endtask

   task automatic fill_ramp();
      for (int i = 0; i < int'(length); i++) i_prd[i] = 16'(i - 16);
   endtask

   // Present the current i_prd until it is accepted (bounded wait)
   task automatic send();
      int guard = 0;
      i_valid = 1'b1;
      while (!o_ready && guard < 100) begin
         step();
         guard++;
      end
      if (guard >= 100) check("send_timeout", 0, 1);
      stalls += guard;
      step();
      acc_cyc = cyc;
      i_valid = 1'b0;
   endtask

   task automatic send_n(input int n, input int v);
      for (int i = 0; i < n; i++) begin
         fill(v);
         send();
      end
   endtask

   task automatic flush();
      repeat (20) step();
   endtask

   task automatic clear_res();
      res_q.delete();
      cyc_q.delete();
   endtask

   task automatic check_res(input string tag, input int idx, input longint exp);
      longint got;
      got = (idx < res_q.size()) ? res_q[idx] : none;
      check(tag, got, exp);
   endtask

   initial begin
      // Reset values, sampled while reset is asserted
      #3;
      check("rst_valid", longint'(o_valid), 0);
      check("rst_sum", longint'(o_sum), 0);
      check("rst_ready", longint'(o_ready), 1);
      repeat (2) @(posedge i_clk);
      #3 i_rst_n = 1'b1;
      step();

      // Basic sum: 4 x 32 lanes of 1
      clear_res();
      send_n(4, 1);
      flush();
      check("basic_count", res_q.size(), 1);
      check_res("basic_sum", 0, 128);
      check("basic_latency", (cyc_q.size() > 0) ? cyc_q[0] - acc_cyc : -1, 7);

      // Negative extreme reaches the most negative result without wrapping
      clear_res();
      send_n(4, -32768);
      flush();
      check("neg_count", res_q.size(), 1);
      check_res("neg_sum", 0, -4194304);

      // Mixed signs: lane i = i-16, each vector sums to -16
      clear_res();
      for (int b = 0; b < 4; b++) begin
         fill_ramp();
         send();
      end
      flush();
      check("mixed_count", res_q.size(), 1);
      check_res("mixed_sum", 0, -64);

      // Back-to-back: 8 vectors of 2 with no gaps
      clear_res();
      stalls = 0;
      send_n(8, 2);
      flush();
      check("b2b_stalls", stalls, 0);
      check("b2b_count", res_q.size(), 2);
      check_res("b2b_sum0", 0, 256);
      check_res("b2b_sum1", 1, 256);
      check("b2b_spacing", (cyc_q.size() > 1) ? cyc_q[1] - cyc_q[0] : -1, 4);

      // Backpressure: result pending with 3 more vectors in flight
      clear_res();
      i_ready = 1'b0;
      send_n(4, 1);
      send_n(3, 2);
      for (int g = 0; g < 20 && !o_valid; g++) step();
      check("bp_valid", longint'(o_valid), 1);
      repeat (5) begin
         step();
         check("bp_ready", longint'(o_ready), 0);
         check("bp_hold", longint'(o_sum), 128);
      end
      i_ready = 1'b1;
      send_n(1, 2);
      flush();
      check("bp_count", res_q.size(), 2);
      check_res("bp_sum0", 0, 128);
      check_res("bp_sum1", 1, 256);

      // Asynchronous reset after 2 blocks discards them
      clear_res();
      send_n(2, 5);
      #3 i_rst_n = 1'b0;
      #1;
      check("mid_rst_valid", longint'(o_valid), 0);
      check("mid_rst_sum", longint'(o_sum), 0);
      check("mid_rst_ready", longint'(o_ready), 1);
      @(posedge i_clk);
      #3 i_rst_n = 1'b1;
      step();
      send_n(4, 3);
      flush();
      check("post_rst_count", res_q.size(), 1);
      check_res("post_rst_sum", 0, 384);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/vec_red_acc_i8.md
Name: vec_red_acc_i8

Overview:
- Consumer side of the elementwise product interface: accepts product vectors in the `vec_mul_i8` output format (`length` signed `prd_width` lanes).
- Reduces each vector to one scalar through a pipelined, registered adder tree.
- Accumulates `num_blocks` consecutive reduced vectors into one dot-product result.
- Presents each result on a valid/ready output with full backpressure. Sits between the vector multiplier and the MX block-scaling / output stage.

Parameters:
- `prd_width`, 16, width of each signed product lane.
- `length`, 32, lanes per input vector; power of two, ≥2.
- `num_blocks`, 4, input vectors summed per output result; ≥1.
- `acc_width`, 23, result width; must be ≥ prd_width + clog2(length) + clog2(num_blocks).

Ports:
- `i_clk`  input  1  clock, rising edge.
- `i_rst_n`  input  1  reset, asynchronous, active-low.
- `i_prd`  input  signed [prd_width-1:0] x length  product vector.
- `i_valid`  input  1  `i_prd` valid.
- `o_ready`  output  1  block can accept `i_prd` this cycle.
- `o_sum`  output  signed [acc_width-1:0]  accumulated dot product.
- `o_valid`  output  1  `o_sum` valid.
- `i_ready`  input  1  downstream accepts `o_sum`.

Behaviour:
- Reset: one clock; reset is asynchronous and active-low (`i_rst_n`). On assertion, the following clear immediately, regardless of clock:
  - all pipeline valid bits, all data registers, the block counter and the accumulator go to 0;
  - `o_valid`=0 and `o_sum`=0;
  - `o_ready`=1 while `i_rst_n`=0, and again after release.
- Reset mid-operation discards any partial accumulation and in-flight vectors. After release, the next accepted vector is block 0 of a new result.
- Global advance: `en = !o_valid || i_ready`.
  - `o_ready = en`, combinational. No combinational path from `i_valid` to `o_ready`.
  - Input transfer occurs when `i_valid && o_ready`.
- Pipeline with T = clog2(length), all stages advancing only when `en`=1:
  - Stage 0 registers `i_prd` and a valid bit.
  - Stages 1..T each register one adder-tree level, halving the lane count. Adds are signed with sign extension; a level-k result is prd_width+k bits wide.
  - The accumulate stage registers the result.
- When `en`=0, every stage holds its data and valid bits. No data is lost and none is duplicated.
- Bubbles: an invalid stage still advances, and its valid bit propagates as 0. The accumulator ignores invalid tree outputs.
- Accumulator behaviour, for each valid tree output `s` with `en`=1, using block counter `cnt` (0..num_blocks-1):
  - If `cnt`==0: `acc <= sext(s)`; otherwise `acc <= acc + sext(s)`.
  - If `cnt`==num_blocks-1: `o_sum <= acc_next`, `o_valid <= 1`, `cnt <= 0`. Otherwise `cnt <= cnt+1`.
  - If `num_blocks`==1, every vector produces a result.
- `o_valid` clears on `o_valid && i_ready` unless a new result is loaded in the same cycle. Simultaneous handshake and new result load the new result and keep `o_valid` high.
- While `o_valid`=1 and `i_ready`=0, `o_sum` is stable.
- Latency: the last block accepted on edge n gives `o_valid`=1 after edge n+T+2. For length=32 this is 7 cycles.
- Throughput: one vector per cycle when `i_ready` is held high.
- Arithmetic: two's complement with no saturation. Overflow is impossible at the minimum legal `acc_width`. With a smaller, illegal `acc_width` the result wraps modulo 2^acc_width; this is not checked.

Test Plan:
- Basic sum: 4 vectors with all lanes = 1, `i_ready`=1 → one result `o_sum`=128, `o_valid` one cycle high, 7 cycles after the 4th accept.
- Negative extreme: 4 vectors with all lanes = -32768 → `o_sum`=-4194304, no wrap.
- Mixed signs: lane i = i-16 for 4 vectors (lane sum -16 each) → `o_sum`=-64.
- Back-to-back throughput: 8 consecutive vectors, all lanes = 2 → two results, each 256, 4 cycles apart; `o_ready` never drops.
- Backpressure: hold `i_ready`=0 while a result is pending, with 3 more vectors in flight:
  - `o_ready`=0 and `o_sum` stable throughout;
  - after release, the next result is correct, with no lost or duplicated block.
- Reset mid-operation: deassert `i_rst_n` asynchronously after 2 blocks are accepted:
  - `o_valid`=0 and `o_sum`=0 immediately;
  - then 4 vectors of all 3 → `o_sum`=384, with no contribution from the pre-reset blocks.
